// File: rtl/jtkcpu_busif_pkg.sv
// Shared constants for the jtkcpu bus interface: state encodings, the
// default watchdog limit and small helpers used by the datapath.
package jtkcpu_busif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } bus_state_e;

    // Default bus watchdog limit in cen cycles.
    localparam int TOUT_DEFAULT = 15;

    // The watchdog counter is never narrower than 4 bits.
    function automatic int wdog_width(input int limit);
        return ($clog2(limit + 1) < 4) ? 4 : $clog2(limit + 1);
    endfunction

    // Pick the high or low byte of a 16-bit word.
    function automatic logic [7:0] sel_byte(input logic [15:0] d, input logic hi);
        return hi ? d[15:8] : d[7:0];
    endfunction

endpackage

// File: rtl/jtkcpu_buswdog.sv
// Bus watchdog for jtkcpu_busif. Counts wait-state cen cycles within one
// byte phase and flags a timeout on the wait cycle that reaches the limit.
// Only present when JTKCPU_BUSERR_EN is defined.
`ifdef JTKCPU_BUSERR_EN
module jtkcpu_buswdog #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen_i,
    input  logic         clear_i,
    input  logic         wait_i,
    input  logic [W-1:0] limit_i,
    output logic         timeout_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: cleared on phase entry/idle, bumped on each wait cen.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cen_i && wait_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The limit-th wait cycle is the one that fires.
    assign timeout_o = cen_i & wait_i & (cnt_q == (limit_i - W'(1)));

endmodule
`endif

// File: rtl/jtkcpu_busif.sv
// jtkcpu bus interface unit: turns one 8/16-bit CPU request into one or two
// big-endian byte cycles on the external 8-bit bus with a bus_ok handshake.
// Optional feature macro: JTKCPU_BUSERR_EN (bus watchdog with buserror pulse).
module jtkcpu_busif
    import jtkcpu_busif_pkg::*;
#(
    parameter int TOUT = TOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen_i,
    input  logic        rd_i,
    input  logic        wrq_i,
    input  logic        mem16_i,
    input  logic        memhi_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] dout_i,
    output logic [15:0] din_o,
    output logic        mem_busy_o,
    output logic        buserror_o,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_dout_o,
    input  logic [7:0]  bus_din_i,
    output logic        bus_cs_o,
    output logic        bus_we_o,
    input  logic        bus_ok_i
);

    bus_state_e  state_q, state_d;

    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        mem16_q, mem16_d;
    logic        memhi_q, memhi_d;
    logic        we_q, we_d;
    logic [15:0] din_q, din_d;

    logic        active;
    logic        done;
    logic        timeout;

    assign active = (state_q != ST_IDLE);
    assign done   = cen_i & bus_ok_i;

`ifdef JTKCPU_BUSERR_EN
    localparam int WD_W = wdog_width(TOUT);

    logic buserror_q, buserror_d;

    jtkcpu_buswdog #(
        .W (WD_W)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .cen_i     (cen_i),
        .clear_i   (~active | done),
        .wait_i    (active & ~bus_ok_i),
        .limit_i   (WD_W'(TOUT)),
        .timeout_o (timeout)
    );

    // buserror lasts exactly one cen period after an abort.
    always_comb begin
        buserror_d = cen_i ? timeout : buserror_q;
    end

    // buserror register.
    always_ff @(posedge clk) begin
        if (rst) begin
            buserror_q <= 1'b0;
        end else begin
            buserror_q <= buserror_d;
        end
    end

    assign buserror_o = buserror_q;
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign buserror_o = 1'b0;
    assign unused_cfg = (TOUT != 0);
`endif

    // State register; reset aborts any access on the next clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: requests only start from IDLE, bus_ok advances a phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cen_i && (rd_i || wrq_i)) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (done) begin
                    state_d = mem16_q ? ST_LO : ST_IDLE;
                end
            end
            ST_LO: begin
                if (timeout || done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the registered state and latched request.
    always_comb begin
        mem_busy_o = active;
        bus_cs_o   = active;
        bus_we_o   = active & we_q;
        bus_addr_o = 16'h0000;
        bus_dout_o = 8'h00;
        case (state_q)
            ST_HI: begin
                bus_addr_o = addr_q;
                bus_dout_o = sel_byte(dout_q, mem16_q | memhi_q);
            end
            ST_LO: begin
                bus_addr_o = addr_q + 16'd1;
                bus_dout_o = dout_q[7:0];
            end
            default: begin
                bus_addr_o = 16'h0000;
                bus_dout_o = 8'h00;
            end
        endcase
    end

    // Request latch and read-data capture; aborted reads return 0xFF bytes.
    always_comb begin
        addr_d  = addr_q;
        dout_d  = dout_q;
        mem16_d = mem16_q;
        memhi_d = memhi_q;
        we_d    = we_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                if (cen_i && (rd_i || wrq_i)) begin
                    addr_d  = addr_i;
                    dout_d  = dout_i;
                    mem16_d = mem16_i;
                    memhi_d = memhi_i;
                    we_d    = wrq_i;
                end
            end
            ST_HI: begin
                if (!we_q) begin
                    if (timeout) begin
                        if (mem16_q) begin
                            din_d = 16'hFFFF;
                        end else if (memhi_q) begin
                            din_d[15:8] = 8'hFF;
                        end else begin
                            din_d[7:0] = 8'hFF;
                        end
                    end else if (done) begin
                        if (mem16_q || memhi_q) begin
                            din_d[15:8] = bus_din_i;
                        end else begin
                            din_d[7:0] = bus_din_i;
                        end
                    end
                end
            end
            ST_LO: begin
                if (!we_q) begin
                    if (timeout) begin
                        din_d[7:0] = 8'hFF;
                    end else if (done) begin
                        din_d[7:0] = bus_din_i;
                    end
                end
            end
            default: begin
                din_d = din_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 16'h0000;
            dout_q  <= 16'h0000;
            mem16_q <= 1'b0;
            memhi_q <= 1'b0;
            we_q    <= 1'b0;
            din_q   <= 16'h0000;
        end else begin
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            mem16_q <= mem16_d;
            memhi_q <= memhi_d;
            we_q    <= we_d;
            din_q   <= din_d;
        end
    end

    assign din_o = din_q;

endmodule
